// File: rtl/bra_rs_pkg.sv
// bra_rs_pkg -- shared definitions for the branch reservation station.
//
// Holds the project-wide branch defines (opcode width, opcode encodings and
// ROB tag width) together with a typed view of the opcodes and a small
// helper used by the station and its bench.

`ifndef BRA_DEFINES_VH
`define BRA_DEFINES_VH
`define BRA_OP_WIDTH    4
`define ROB_ENTRY_WIDTH 4
`define BEQ             4'd1
`define BNE             4'd2
`define BLT             4'd3
`define BGE             4'd4
`define BLTU            4'd5
`define BGEU            4'd6
`define JAL             4'd7
`define JALR            4'd8
`endif

package bra_rs_pkg;

    localparam int OP_W   = `BRA_OP_WIDTH;
    localparam int DATA_W = 32;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = '0,
        OP_BEQ  = `BEQ,
        OP_BNE  = `BNE,
        OP_BLT  = `BLT,
        OP_BGE  = `BGE,
        OP_BLTU = `BLTU,
        OP_BGEU = `BGEU,
        OP_JAL  = `JAL,
        OP_JALR = `JALR
    } bra_op_e;

    // Opcode zero is the no-op marker on both the dispatch and issue sides.
    function automatic logic op_valid(input logic [OP_W-1:0] op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/bra_rs_pick.sv
// bra_rs_pick -- lowest-index one-hot priority selector.
//
// Ports:
//   req  in   N  request vector
//   gnt  out  N  one-hot grant for the lowest set bit of req (all zero if none)

module bra_rs_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    always_comb begin
        gnt = '0;
        // Walk from the top down so the lowest requester is the last writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bra_rs.sv
// bra_rs -- branch reservation station.
//
// Holds dispatched branches until both operands are available (watching the
// CDB for producer tags), then issues the lowest-index ready entry into a
// registered bundle for the branch execution unit, one per cycle.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   disp_*                           dispatch request and branch payload
//   cdb_valid, cdb_tag, cdb_value    common-data-bus broadcast
//   flush                            squash all entries and any issue
//   rs_full, rs_count                occupancy, from the registered valid bits
//   BRAOp, BRASrcA, BRASrcB,
//   PC, Offset, Dest_in              registered issue bundle (BRAOp=0: idle)

import bra_rs_pkg::*;

module bra_rs #(
    parameter int RS_DEPTH = 4,
    parameter int TAG_W    = `ROB_ENTRY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         disp_valid,
    input  logic [`BRA_OP_WIDTH-1:0]     disp_op,
    input  logic [31:0]                  disp_vj,
    input  logic [31:0]                  disp_vk,
    input  logic [TAG_W-1:0]             disp_qj,
    input  logic [TAG_W-1:0]             disp_qk,
    input  logic                         disp_qj_busy,
    input  logic                         disp_qk_busy,
    input  logic [31:0]                  disp_pc,
    input  logic [31:0]                  disp_offset,
    input  logic [TAG_W-1:0]             disp_dest,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_value,
    input  logic                         flush,
    output logic                         rs_full,
    output logic [$clog2(RS_DEPTH):0]    rs_count,
    output logic [`BRA_OP_WIDTH-1:0]     BRAOp,
    output logic [31:0]                  BRASrcA,
    output logic [31:0]                  BRASrcB,
    output logic [31:0]                  PC,
    output logic [31:0]                  Offset,
    output logic [TAG_W-1:0]             Dest_in
);

    localparam int CNT_W = $clog2(RS_DEPTH) + 1;

    // Entry storage: control bits are reset, payload is not.
    logic [RS_DEPTH-1:0] valid;
    logic [RS_DEPTH-1:0] qj_busy;
    logic [RS_DEPTH-1:0] qk_busy;
    logic [OP_W-1:0]     op     [RS_DEPTH];
    logic [DATA_W-1:0]   vj     [RS_DEPTH];
    logic [DATA_W-1:0]   vk     [RS_DEPTH];
    logic [TAG_W-1:0]    qj     [RS_DEPTH];
    logic [TAG_W-1:0]    qk     [RS_DEPTH];
    logic [DATA_W-1:0]   pc     [RS_DEPTH];
    logic [DATA_W-1:0]   offset [RS_DEPTH];
    logic [TAG_W-1:0]    dest   [RS_DEPTH];

    logic [RS_DEPTH-1:0] ready;
    logic [RS_DEPTH-1:0] free_gnt;
    logic [RS_DEPTH-1:0] rdy_gnt;
    logic [RS_DEPTH-1:0] wake_j;
    logic [RS_DEPTH-1:0] wake_k;
    logic                rdy_any;
    logic                disp_accept;
    logic                disp_wake_j;
    logic                disp_wake_k;
    logic [DATA_W-1:0]   disp_vj_eff;
    logic [DATA_W-1:0]   disp_vk_eff;
    logic [CNT_W-1:0]    count;

    // Issue mux outputs (one-hot and-or over the ready grant).
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_vj;
    logic [DATA_W-1:0]   sel_vk;
    logic [DATA_W-1:0]   sel_pc;
    logic [DATA_W-1:0]   sel_offset;
    logic [TAG_W-1:0]    sel_dest;

    // Readiness and free slots look only at registered state, so an entry
    // written or woken at an edge is first visible one cycle later, and a slot
    // freed by issue is not reused at the same edge.
    assign ready   = valid & ~qj_busy & ~qk_busy;
    assign rdy_any = |rdy_gnt;

    bra_rs_pick #(.N(RS_DEPTH)) u_pick_free (
        .req (~valid),
        .gnt (free_gnt)
    );

    bra_rs_pick #(.N(RS_DEPTH)) u_pick_ready (
        .req (ready),
        .gnt (rdy_gnt)
    );

    assign disp_accept = disp_valid && !rs_full && !flush && op_valid(disp_op);

    // A broadcast in the dispatch cycle is forwarded straight into the new entry.
    assign disp_wake_j = cdb_valid && disp_qj_busy && (disp_qj == cdb_tag);
    assign disp_wake_k = cdb_valid && disp_qk_busy && (disp_qk == cdb_tag);
    assign disp_vj_eff = disp_wake_j ? cdb_value : disp_vj;
    assign disp_vk_eff = disp_wake_k ? cdb_value : disp_vk;

    always_comb begin
        wake_j = '0;
        wake_k = '0;
        count  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            wake_j[i] = cdb_valid && valid[i] && qj_busy[i] && (qj[i] == cdb_tag);
            wake_k[i] = cdb_valid && valid[i] && qk_busy[i] && (qk[i] == cdb_tag);
            count     = count + {{(CNT_W-1){1'b0}}, valid[i]};
        end
    end

    assign rs_count = count;
    assign rs_full  = &valid;

    always_comb begin
        sel_op     = '0;
        sel_vj     = '0;
        sel_vk     = '0;
        sel_pc     = '0;
        sel_offset = '0;
        sel_dest   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            sel_op     = sel_op     | ({OP_W{rdy_gnt[i]}}   & op[i]);
            sel_vj     = sel_vj     | ({DATA_W{rdy_gnt[i]}} & vj[i]);
            sel_vk     = sel_vk     | ({DATA_W{rdy_gnt[i]}} & vk[i]);
            sel_pc     = sel_pc     | ({DATA_W{rdy_gnt[i]}} & pc[i]);
            sel_offset = sel_offset | ({DATA_W{rdy_gnt[i]}} & offset[i]);
            sel_dest   = sel_dest   | ({TAG_W{rdy_gnt[i]}}  & dest[i]);
        end
    end

    // ---- entry control: valid and operand-pending flags ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= '0;
            qj_busy <= '0;
            qk_busy <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            valid <= (valid & ~rdy_gnt) | (disp_accept ? free_gnt : '0);
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (disp_accept && free_gnt[i]) begin
                    qj_busy[i] <= disp_qj_busy && !disp_wake_j;
                    qk_busy[i] <= disp_qk_busy && !disp_wake_k;
                end else begin
                    if (wake_j[i]) qj_busy[i] <= 1'b0;
                    if (wake_k[i]) qk_busy[i] <= 1'b0;
                end
            end
        end
    end

    // ---- entry payload: written on dispatch, operands replaced on wakeup ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (disp_accept && free_gnt[i]) begin
                op[i]     <= disp_op;
                vj[i]     <= disp_vj_eff;
                vk[i]     <= disp_vk_eff;
                qj[i]     <= disp_qj;
                qk[i]     <= disp_qk;
                pc[i]     <= disp_pc;
                offset[i] <= disp_offset;
                dest[i]   <= disp_dest;
            end else begin
                if (wake_j[i]) vj[i] <= cdb_value;
                if (wake_k[i]) vk[i] <= cdb_value;
            end
        end
    end

    // ---- issue register: BRAOp=0 marks an idle cycle, payload holds ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BRAOp   <= '0;
            BRASrcA <= '0;
            BRASrcB <= '0;
            PC      <= '0;
            Offset  <= '0;
            Dest_in <= '0;
        end else if (flush || !rdy_any) begin
            BRAOp <= '0;
        end else begin
            BRAOp   <= sel_op;
            BRASrcA <= sel_vj;
            BRASrcB <= sel_vk;
            PC      <= sel_pc;
            Offset  <= sel_offset;
            Dest_in <= sel_dest;
        end
    end

endmodule

// File: tb/tb_bra_rs.sv
// tb_bra_rs -- directed self-checking bench for bra_rs.
//
// Inputs change 1 ns after a rising edge; outputs are checked in that same
// window, i.e. they reflect the state loaded at the preceding edge.

import bra_rs_pkg::*;

module tb_bra_rs;

    localparam int RS_DEPTH = 4;
    localparam int TAG_W    = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       disp_valid;
    logic [3:0]                 disp_op;
    logic [31:0]                disp_vj, disp_vk;
    logic [TAG_W-1:0]           disp_qj, disp_qk;
    logic                       disp_qj_busy, disp_qk_busy;
    logic [31:0]                disp_pc, disp_offset;
    logic [TAG_W-1:0]           disp_dest;
    logic                       cdb_valid;
    logic [TAG_W-1:0]           cdb_tag;
    logic [31:0]                cdb_value;
    logic                       flush;
    logic                       rs_full;
    logic [$clog2(RS_DEPTH):0]  rs_count;
    logic [3:0]                 BRAOp;
    logic [31:0]                BRASrcA, BRASrcB, PC, Offset;
    logic [TAG_W-1:0]           Dest_in;

    int n_cmp = 0;
    int n_bad = 0;

    bra_rs #(.RS_DEPTH(RS_DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .disp_valid   (disp_valid),
        .disp_op      (disp_op),
        .disp_vj      (disp_vj),
        .disp_vk      (disp_vk),
        .disp_qj      (disp_qj),
        .disp_qk      (disp_qk),
        .disp_qj_busy (disp_qj_busy),
        .disp_qk_busy (disp_qk_busy),
        .disp_pc      (disp_pc),
        .disp_offset  (disp_offset),
        .disp_dest    (disp_dest),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .flush        (flush),
        .rs_full      (rs_full),
        .rs_count     (rs_count),
        .BRAOp        (BRAOp),
        .BRASrcA      (BRASrcA),
        .BRASrcB      (BRASrcB),
        .PC           (PC),
        .Offset       (Offset),
        .Dest_in      (Dest_in)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                              input logic [TAG_W-1:0] qj, input logic qjb,
                              input logic [TAG_W-1:0] qk, input logic qkb,
                              input logic [31:0] pc, input logic [31:0] off,
                              input logic [TAG_W-1:0] dest);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_vj      = vj;
        disp_vk      = vk;
        disp_qj      = qj;
        disp_qj_busy = qjb;
        disp_qk      = qk;
        disp_qk_busy = qkb;
        disp_pc      = pc;
        disp_offset  = off;
        disp_dest    = dest;
    endtask

    task automatic drive_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] value);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = value;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        disp_op    = '0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
        disp_qj_busy = 1'b0; disp_qk_busy = 1'b0;
        disp_pc = '0; disp_offset = '0; disp_dest = '0;
        cdb_tag = '0; cdb_value = '0;

        // Reset state
        tick();
        tick();
        chk_val("rst_count", rs_count, 0);
        chk_val("rst_full", rs_full, 0);
        chk_val("rst_op", BRAOp, 0);
        chk_val("rst_srca", BRASrcA, 0);
        chk_val("rst_dest", Dest_in, 0);
        rst_n = 1'b1;
        tick();

        // Dispatch with opcode 0 is ignored
        drive_disp(4'd0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle();
        chk_val("nop_count", rs_count, 0);
        tick();
        chk_val("nop_issue", BRAOp, 0);

        // BEQ ready at dispatch: issue visible two cycles later
        drive_disp(OP_BEQ, 5, 5, 0, 0, 0, 0, 32'h40, 32'h10, 3);
        tick();
        idle();
        chk_val("beq_c1_count", rs_count, 1);
        chk_val("beq_c1_op", BRAOp, 0);
        tick();
        chk_val("beq_op", BRAOp, OP_BEQ);
        chk_val("beq_srca", BRASrcA, 5);
        chk_val("beq_srcb", BRASrcB, 5);
        chk_val("beq_dest", Dest_in, 3);
        chk_val("beq_pc", PC, 32'h40);
        chk_val("beq_off", Offset, 32'h10);
        chk_val("beq_count", rs_count, 0);
        tick();
        chk_val("beq_after_op", BRAOp, 0);
        chk_val("beq_hold_srca", BRASrcA, 5);

        // BNE waiting on tag 7; wrong tag first, then tag 7 in cycle 3
        drive_disp(OP_BNE, 32'hDEAD, 32'h22, 7, 1, 0, 0, 32'h100, 32'h8, 4);
        tick();                               // cycle 1
        idle();
        drive_cdb(6, 32'h99);
        tick();                               // cycle 2
        idle();
        chk_val("bne_c2_op", BRAOp, 0);
        tick();                               // cycle 3
        chk_val("bne_c3_op", BRAOp, 0);
        chk_val("bne_c3_count", rs_count, 1);
        drive_cdb(7, 32'h10);
        tick();                               // cycle 4
        idle();
        chk_val("bne_c4_op", BRAOp, 0);
        tick();                               // cycle 5
        chk_val("bne_op", BRAOp, OP_BNE);
        chk_val("bne_srca", BRASrcA, 32'h10);
        chk_val("bne_srcb", BRASrcB, 32'h22);
        chk_val("bne_dest", Dest_in, 4);
        tick();

        // Dispatch with qk=2 busy alongside CDB tag 2 value 9
        drive_disp(OP_BLT, 1, 32'h77, 0, 0, 2, 1, 32'h200, 32'h4, 5);
        drive_cdb(2, 9);
        tick();
        idle();
        chk_val("fwd_c1_count", rs_count, 1);
        tick();
        chk_val("fwd_op", BRAOp, OP_BLT);
        chk_val("fwd_srcb", BRASrcB, 9);
        chk_val("fwd_srca", BRASrcA, 1);
        tick();

        // Fill all four entries waiting on tag 1, drop a fifth
        for (int i = 0; i < 4; i++) begin
            drive_disp(OP_BEQ, 0, 32'h30 + i, 1, 1, 0, 0, 32'h300 + 4*i, 32'h0, 4'(8 + i));
            tick();
        end
        idle();
        chk_val("full_flag", rs_full, 1);
        chk_val("full_count", rs_count, 4);
        drive_disp(OP_BGE, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        tick();
        idle();
        chk_val("full_drop_count", rs_count, 4);
        chk_val("full_no_issue", BRAOp, 0);
        drive_cdb(1, 32'h55);
        tick();
        idle();
        chk_val("full_woken_count", rs_count, 4);
        chk_val("full_woken_op", BRAOp, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_val($sformatf("full_iss%0d_op", i), BRAOp, OP_BEQ);
            chk_val($sformatf("full_iss%0d_dest", i), Dest_in, 8 + i);
            chk_val($sformatf("full_iss%0d_srca", i), BRASrcA, 32'h55);
            chk_val($sformatf("full_iss%0d_srcb", i), BRASrcB, 32'h30 + i);
            chk_val($sformatf("full_iss%0d_count", i), rs_count, 3 - i);
        end
        tick();
        chk_val("full_drain_op", BRAOp, 0);

        // Flush with dispatch, wakeup and a ready entry in the same cycle
        drive_disp(OP_BGE, 0, 0, 5, 1, 0, 0, 32'h400, 0, 1);
        tick();
        drive_disp(OP_BGE, 0, 0, 5, 1, 0, 0, 32'h404, 0, 2);
        tick();
        drive_disp(OP_BEQ, 32'hAA, 32'hAA, 0, 0, 0, 0, 32'h408, 0, 3);
        tick();
        chk_val("flush_pre_count", rs_count, 3);
        drive_disp(OP_BEQ, 32'hBB, 32'hBB, 0, 0, 0, 0, 32'h40C, 0, 4);
        drive_cdb(5, 32'h66);
        flush = 1'b1;
        tick();
        idle();
        chk_val("flush_count", rs_count, 0);
        chk_val("flush_full", rs_full, 0);
        chk_val("flush_op", BRAOp, 0);
        tick();
        chk_val("flush_later_op1", BRAOp, 0);
        tick();
        chk_val("flush_later_op2", BRAOp, 0);
        chk_val("flush_hold_srca", BRASrcA, 32'h55);

        // Asynchronous reset mid-stream with two entries held
        drive_disp(OP_BLTU, 1, 2, 6, 1, 0, 0, 32'h500, 32'h20, 6);
        tick();
        drive_disp(OP_BGEU, 3, 4, 6, 1, 0, 0, 32'h504, 32'h24, 7);
        tick();
        idle();
        chk_val("rst2_pre_count", rs_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("rst2_count", rs_count, 0);
        chk_val("rst2_full", rs_full, 0);
        chk_val("rst2_op", BRAOp, 0);
        chk_val("rst2_srca", BRASrcA, 0);
        chk_val("rst2_srcb", BRASrcB, 0);
        chk_val("rst2_pc", PC, 0);
        chk_val("rst2_off", Offset, 0);
        chk_val("rst2_dest", Dest_in, 0);
        tick();
        rst_n = 1'b1;
        drive_cdb(6, 32'h77);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_val($sformatf("rst2_post_op%0d", i), BRAOp, 0);
            chk_val($sformatf("rst2_post_count%0d", i), rs_count, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bra_rs.md
BRA_RS -- requirements
Module: bra_rs

Interface
REQ-001 The module SHALL have parameter RS_DEPTH, default 4, giving the number of branch reservation-station entries (power of two, 2..8).
REQ-002 The module SHALL have parameter TAG_W, default `ROB_ENTRY_WIDTH, giving the ROB tag width.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 disp_valid  input  1  dispatch request this cycle.
REQ-006 disp_op  input  `BRA_OP_WIDTH  branch opcode; 0 means no-op.
REQ-007 disp_vj, disp_vk  input  32 each  operand values, meaningful when the matching disp_qj_busy/disp_qk_busy is 0.
REQ-008 disp_qj, disp_qk  input  TAG_W each  producer ROB tags.
REQ-009 disp_qj_busy, disp_qk_busy  input  1 each  operand still pending.
REQ-010 disp_pc, disp_offset  input  32 each  instruction PC and immediate.
REQ-011 disp_dest  input  TAG_W  ROB tag of the branch.
REQ-012 cdb_valid  input  1; cdb_tag  input  TAG_W; cdb_value  input  32  common-data-bus broadcast.
REQ-013 flush  input  1  misprediction squash.
REQ-014 rs_full  output  1  all entries occupied.
REQ-015 rs_count  output  $clog2(RS_DEPTH)+1  number of occupied entries.
REQ-016 BRAOp, BRASrcA, BRASrcB, PC, Offset, Dest_in  output  widths `BRA_OP_WIDTH/32/32/32/32/TAG_W  registered issue bundle to the branch execution unit.

Function
REQ-017 Each entry SHALL hold: valid, op, vj, vk, qj, qk, qj_busy, qk_busy, pc, offset, dest.
REQ-018 An accepted dispatch (disp_valid=1, rs_full=0, flush=0) SHALL write the lowest-index free entry at the clock edge.
REQ-019 A dispatch while rs_full=1 SHALL be ignored with no state change.
REQ-020 A dispatch with disp_op=0 SHALL be ignored.
REQ-021 When cdb_valid=1, any valid entry with qj_busy=1 and qj==cdb_tag SHALL load vj=cdb_value and clear qj_busy; qk is handled identically and independently.
REQ-022 A dispatch in the same cycle as a matching CDB broadcast SHALL capture cdb_value in place of disp_vj/disp_vk and write the busy flag as 0.
REQ-023 An entry SHALL be ready when valid=1, qj_busy=0 and qk_busy=0, evaluated from the registered state only.
REQ-024 An entry written or woken at edge E SHALL first be selectable in the cycle after E.
REQ-025 Each cycle, the lowest-index ready entry SHALL be selected; at the edge its fields SHALL load the issue registers and its valid bit SHALL clear.
REQ-026 Issue latency: entry ready in cycle C implies BRAOp nonzero with its fields during cycle C+1 only.
REQ-027 If no entry is ready, BRAOp SHALL load 0 and the other issue outputs SHALL hold their previous values.
REQ-028 At most one issue and one dispatch per cycle; an entry freed at edge E SHALL be reusable by a dispatch at the next edge, not at edge E.
REQ-029 rs_full and rs_count SHALL be derived combinationally from the registered valid bits.
REQ-030 flush=1 SHALL clear all valid bits and load BRAOp=0 at the edge, overriding dispatch, wakeup and issue in the same cycle.

Reset
REQ-031 While rst_n=0: all valid bits 0, BRAOp=0, BRASrcA=BRASrcB=PC=Offset=0, Dest_in=0, rs_full=0, rs_count=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately with no issue afterward.

Structure
REQ-033 `BRA_OP_WIDTH, the opcode encodings (`BEQ..`JALR) and `ROB_ENTRY_WIDTH SHALL come from the shared defines.vh.
REQ-034 A sub-module bra_rs_pick (lowest-index one-hot priority selector, RS_DEPTH wide) SHALL be used for both free-slot allocation and ready-entry selection.

Verification
REQ-035 Dispatch BEQ, vj=vk=5, both not busy, dest=3 at cycle 0 -> BRAOp=`BEQ, BRASrcA=BRASrcB=5, Dest_in=3 in cycle 2; rs_count returns to 0.
REQ-036 Dispatch BNE with qj_busy=1, qj=7; CDB tag 7 value 0x10 at cycle 3 -> issue in cycle 5 with BRASrcA=0x10.
REQ-037 Dispatch with qk=2 busy in the same cycle as CDB tag 2 value 9 -> entry ready next cycle; BRASrcB=9 at issue.
REQ-038 Fill 4 entries all waiting on tag 1 -> rs_full=1; a 5th dispatch is dropped; CDB tag 1 -> issues from entries 0,1,2,3 on consecutive cycles.
REQ-039 Three entries valid, flush plus disp_valid in the same cycle -> rs_count=0 and BRAOp=0 next cycle; no later issue.
REQ-040 rst_n low for 1 cycle mid-stream with 2 entries held -> all outputs at reset values; no issue after release.
